// File: rtl/pci_master.sv
// ---------------------------------------------------------------------------
// pci_master
//
// Single-channel PCI bus master. A user request (start/cmd/addr/count) is
// turned into one bus transaction of 1-4 data phases. The bus is requested
// from the arbiter and the address phase is driven. Data phases then run
// until the burst completes, the target disconnects with STOP#, or no target
// claims the cycle within TIMEOUT data clocks (master abort).
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   start, cmd, addr, count  user request, sampled while busy = 0
//   wdata / wdata_ack        write word from user / word-consumed pulse
//   rdata / rdata_valid      captured read word / capture pulse
//   busy, done, abort        status: transaction active / normal end / abort
//   req_n, gnt_n             arbiter request / grant
//   frame_n_out/_oe/_in      FRAME# drive value, enable, sampled bus value
//   irdy_n_out/_oe/_in       IRDY# drive value, enable, sampled bus value
//   trdy_n, devsel_n, stop_n target responses
//   ad_out/ad_oe/ad_in       AD drive value, enable, sampled bus value
//   cbe_out/cbe_oe           C/BE# drive value, enable
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module pci_master #(
    parameter int TIMEOUT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  cmd,
    input  logic [31:0] addr,
    input  logic [2:0]  count,
    input  logic [31:0] wdata,
    output logic        wdata_ack,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        busy,
    output logic        done,
    output logic        abort,
    output logic        req_n,
    input  logic        gnt_n,
    output logic        frame_n_out,
    output logic        frame_oe,
    input  logic        frame_n_in,
    output logic        irdy_n_out,
    output logic        irdy_oe,
    input  logic        irdy_n_in,
    input  logic        trdy_n,
    input  logic        devsel_n,
    input  logic        stop_n,
    output logic [31:0] ad_out,
    output logic        ad_oe,
    input  logic [31:0] ad_in,
    output logic [3:0]  cbe_out,
    output logic        cbe_oe
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_END  = 3'd4;

    localparam logic [3:0] CMD_READ = 4'b0110;
    localparam int         TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // control state
    logic [2:0]    state_q, state_d;
    logic          is_read_q, is_read_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [2:0]    remain_q, remain_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          devsel_seen_q, devsel_seen_d;
    // release_q marks the single FRAME#-high / IRDY#-low clock that precedes
    // END after a master abort or a target stop
    logic          release_q, release_d;

    // registered outputs
    logic          req_n_q, req_n_d;
    logic          frame_n_q, frame_n_d;
    logic          frame_oe_q, frame_oe_d;
    logic          irdy_n_q, irdy_n_d;
    logic          irdy_oe_q, irdy_oe_d;
    logic [31:0]   ad_out_q, ad_out_d;
    logic          ad_oe_q, ad_oe_d;
    logic [3:0]    cbe_out_q, cbe_out_d;
    logic          cbe_oe_q, cbe_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          abort_q, abort_d;
    logic          wdata_ack_q, wdata_ack_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rdata_valid_q, rdata_valid_d;

    // A word moves on an edge where our IRDY# is asserted and the target
    // answers with TRDY# and DEVSEL#. The release clock never transfers.
    logic xfer;
    assign xfer = (state_q == S_DATA) && !release_q && !irdy_n_q && !trdy_n && !devsel_n;

    always_comb begin
        state_d       = state_q;
        is_read_d     = is_read_q;
        addr_d        = addr_q;
        cmd_d         = cmd_q;
        remain_d      = remain_q;
        tcnt_d        = tcnt_q;
        devsel_seen_d = devsel_seen_q;
        release_d     = release_q;
        req_n_d       = req_n_q;
        frame_n_d     = frame_n_q;
        frame_oe_d    = frame_oe_q;
        irdy_n_d      = irdy_n_q;
        irdy_oe_d     = irdy_oe_q;
        ad_out_d      = ad_out_q;
        ad_oe_d       = ad_oe_q;
        cbe_out_d     = cbe_out_q;
        cbe_oe_d      = cbe_oe_q;
        busy_d        = busy_q;
        rdata_d       = rdata_q;
        done_d        = 1'b0;
        abort_d       = 1'b0;
        wdata_ack_d   = 1'b0;
        rdata_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cmd_d     = cmd;
                    addr_d    = addr;
                    remain_d  = (count == 3'd0) ? 3'd1 : count;
                    is_read_d = (cmd == CMD_READ);
                    busy_d    = 1'b1;
                    req_n_d   = 1'b0;
                    state_d   = S_REQ;
                end
            end

            S_REQ: begin
                // a grant is only usable once the previous owner has left the bus
                if (!gnt_n && frame_n_in && irdy_n_in) begin
                    req_n_d    = 1'b1;
                    frame_n_d  = 1'b0;
                    frame_oe_d = 1'b1;
                    ad_out_d   = addr_q;
                    ad_oe_d    = 1'b1;
                    cbe_out_d  = cmd_q;
                    cbe_oe_d   = 1'b1;
                    state_d    = S_ADDR;
                end
            end

            S_ADDR: begin
                irdy_n_d      = 1'b0;
                irdy_oe_d     = 1'b1;
                cbe_out_d     = 4'b0000;
                ad_out_d      = is_read_q ? ad_out_q : wdata;
                ad_oe_d       = !is_read_q;
                frame_n_d     = (remain_q == 3'd1);
                tcnt_d        = '0;
                devsel_seen_d = 1'b0;
                release_d     = 1'b0;
                state_d       = S_DATA;
            end

            S_DATA: begin
                if (xfer) begin
                    if (is_read_q) begin
                        rdata_d       = ad_in;
                        rdata_valid_d = 1'b1;
                    end else begin
                        wdata_ack_d = 1'b1;
                    end
                end
                if (!release_q && !devsel_n) begin
                    devsel_seen_d = 1'b1;
                end

                if (release_q) begin
                    frame_n_d = 1'b1;
                    irdy_n_d  = 1'b1;
                    abort_d   = 1'b1;
                    state_d   = S_END;
                end else if (!stop_n && !devsel_n) begin
                    // target disconnect: the word (if TRDY#) already moved above
                    frame_n_d = 1'b1;
                    irdy_n_d  = 1'b0;
                    release_d = 1'b1;
                end else if (xfer) begin
                    remain_d = remain_q - 3'd1;
                    if (remain_q == 3'd1) begin
                        frame_n_d = 1'b1;
                        irdy_n_d  = 1'b1;
                        done_d    = 1'b1;
                        state_d   = S_END;
                    end else if (!is_read_q) begin
                        // The next write word only appears after the user sees
                        // wdata_ack, so IRDY# is withdrawn for one clock while
                        // it is fetched. FRAME# must stay low while IRDY# is high.
                        irdy_n_d  = 1'b1;
                        frame_n_d = 1'b0;
                    end else begin
                        frame_n_d = (remain_q == 3'd2);
                    end
                end else if (irdy_n_q) begin
                    // end of the write fetch clock: present the new word
                    irdy_n_d  = 1'b0;
                    ad_out_d  = wdata;
                    frame_n_d = (remain_q == 3'd1);
                end else if (devsel_n && !devsel_seen_q) begin
                    if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        frame_n_d = 1'b1;
                        release_d = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end

            S_END: begin
                frame_oe_d = 1'b0;
                irdy_oe_d  = 1'b0;
                ad_oe_d    = 1'b0;
                cbe_oe_d   = 1'b0;
                busy_d     = 1'b0;
                release_d  = 1'b0;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            is_read_q     <= 1'b0;
            addr_q        <= '0;
            cmd_q         <= '0;
            remain_q      <= '0;
            tcnt_q        <= '0;
            devsel_seen_q <= 1'b0;
            release_q     <= 1'b0;
            req_n_q       <= 1'b1;
            frame_n_q     <= 1'b1;
            frame_oe_q    <= 1'b0;
            irdy_n_q      <= 1'b1;
            irdy_oe_q     <= 1'b0;
            ad_out_q      <= '0;
            ad_oe_q       <= 1'b0;
            cbe_out_q     <= 4'hF;
            cbe_oe_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            abort_q       <= 1'b0;
            wdata_ack_q   <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            is_read_q     <= is_read_d;
            addr_q        <= addr_d;
            cmd_q         <= cmd_d;
            remain_q      <= remain_d;
            tcnt_q        <= tcnt_d;
            devsel_seen_q <= devsel_seen_d;
            release_q     <= release_d;
            req_n_q       <= req_n_d;
            frame_n_q     <= frame_n_d;
            frame_oe_q    <= frame_oe_d;
            irdy_n_q      <= irdy_n_d;
            irdy_oe_q     <= irdy_oe_d;
            ad_out_q      <= ad_out_d;
            ad_oe_q       <= ad_oe_d;
            cbe_out_q     <= cbe_out_d;
            cbe_oe_q      <= cbe_oe_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            abort_q       <= abort_d;
            wdata_ack_q   <= wdata_ack_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign req_n       = req_n_q;
    assign frame_n_out = frame_n_q;
    assign frame_oe    = frame_oe_q;
    assign irdy_n_out  = irdy_n_q;
    assign irdy_oe     = irdy_oe_q;
    assign ad_out      = ad_out_q;
    assign ad_oe       = ad_oe_q;
    assign cbe_out     = cbe_out_q;
    assign cbe_oe      = cbe_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign abort       = abort_q;
    assign wdata_ack   = wdata_ack_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_pci_master.sv
// ---------------------------------------------------------------------------
// tb_pci_master
//
// Table of transaction scenarios (arbiter delay, bus-busy time, target
// behaviour) with the expected word count, completion type and phase timing.
// Expected words go into a scoreboard queue when a transaction is launched and
// are popped as wdata_ack / rdata_valid pulses appear. Hand-written sequences
// cover reset values and a reset in the middle of a burst.
// ---------------------------------------------------------------------------
module tb_pci_master;

    localparam int TIMEOUT = 5;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [2:0]  count;
    logic [31:0] wdata;
    logic        wdata_ack;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        busy;
    logic        done;
    logic        abort;
    logic        req_n;
    logic        gnt_n;
    logic        frame_n_out;
    logic        frame_oe;
    logic        frame_n_in;
    logic        irdy_n_out;
    logic        irdy_oe;
    logic        irdy_n_in;
    logic        trdy_n;
    logic        devsel_n;
    logic        stop_n;
    logic [31:0] ad_out;
    logic        ad_oe;
    logic [31:0] ad_in;
    logic [3:0]  cbe_out;
    logic        cbe_oe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pci_master #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .addr(addr),
        .count(count), .wdata(wdata), .wdata_ack(wdata_ack), .rdata(rdata),
        .rdata_valid(rdata_valid), .busy(busy), .done(done), .abort(abort),
        .req_n(req_n), .gnt_n(gnt_n), .frame_n_out(frame_n_out),
        .frame_oe(frame_oe), .frame_n_in(frame_n_in), .irdy_n_out(irdy_n_out),
        .irdy_oe(irdy_oe), .irdy_n_in(irdy_n_in), .trdy_n(trdy_n),
        .devsel_n(devsel_n), .stop_n(stop_n), .ad_out(ad_out), .ad_oe(ad_oe),
        .ad_in(ad_in), .cbe_out(cbe_out), .cbe_oe(cbe_oe)
    );

    // rd/cnt: request; gdly: first cycle with gnt_n=0; bbusy: cycles the bus
    // is owned by someone else; dev: target claims; wword/wlen: TRDY# stall;
    // sword: word with STOP#; poke: second start while busy.
    // e_*: expected words, done, and cycle numbers (counted in falling edges
    // after start) of the address phase, FRAME# rise and busy low.
    typedef struct {
        bit         rd;
        logic [2:0] cnt;
        int         gdly;
        int         bbusy;
        bit         dev;
        int         wword;
        int         wlen;
        int         sword;
        bit         poke;
        int         e_words;
        bit         e_done;
        int         e_addr;
        int         e_frise;
        int         e_idle;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] sb_q[$];
    int          vectors;
    int          miscompares;

    task automatic chk_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string name);
        chk32({name, "_ctl"},
              {20'd0, req_n, frame_n_out, irdy_n_out, frame_oe, irdy_oe, ad_oe, cbe_oe,
               busy, done, abort, wdata_ack, rdata_valid},
              32'h0000_0E00);
        chk32({name, "_rdata"}, rdata, 32'h0);
        chk32({name, "_ad_out"}, ad_out, 32'h0);
        chk32({name, "_cbe_out"}, {28'd0, cbe_out}, 32'hF);
    endtask

    // Called on a falling edge; start is driven immediately so back-to-back
    // calls present start in the first clock that busy is low.
    task automatic run_txn(input int vi, input vec_t v);
        logic [31:0] wbase, rbase, a, prev_ad, addr_ad, exp_w;
        logic [3:0]  c, addr_cbe;
        int tidx, wleft, widx, words, ndone, nabort, nreq, addr_cyc, frise, idle_cyc;
        bit fin;

        wbase = 32'hA000_0000 + 32'(vi * 16);
        rbase = (vi == 1) ? 32'h10 : 32'h5000_0000 + 32'(vi * 16);
        a     = 32'h8000_0000 + 32'(vi * 256);
        c     = v.rd ? 4'b0110 : 4'b0111;
        for (int i = 0; i < v.e_words; i++)
            sb_q.push_back(v.rd ? rbase + 32'(i) : wbase + 32'(i));

        cmd = c; addr = a; count = v.cnt; wdata = wbase; start = 1'b1;
        gnt_n = 1'b1; frame_n_in = 1'b1; irdy_n_in = 1'b1;
        devsel_n = 1'b1; trdy_n = 1'b1; stop_n = 1'b1; ad_in = 32'h0;
        tidx = 0; wleft = v.wlen; widx = 0; words = 0; ndone = 0; nabort = 0; nreq = 0;
        addr_cyc = -1; frise = -1; idle_cyc = -1; fin = 1'b0;
        prev_ad = 32'h0; addr_ad = 32'h0; addr_cbe = 4'h0;

        for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
            @(negedge clk);
            start = (v.poke && cyc == 3);
            if (v.poke && cyc == 3) addr = 32'hDEAD_0000;

            if (wdata_ack) begin
                words++;
                if (sb_q.size() == 0) begin
                    chk32("extra_wdata_ack", prev_ad, 32'hxxxx_xxxx);
                end else begin
                    exp_w = sb_q.pop_front();
                    chk32("write_word", prev_ad, exp_w);
                end
                widx++;
                wdata = wbase + 32'(widx);
            end
            if (rdata_valid) begin
                words++;
                if (sb_q.size() == 0) begin
                    chk32("extra_rdata_valid", rdata, 32'hxxxx_xxxx);
                end else begin
                    exp_w = sb_q.pop_front();
                    chk32("read_word", rdata, exp_w);
                end
            end
            if (done) ndone++;
            if (abort) nabort++;
            if (!req_n) nreq++;
            if (addr_cyc < 0 && frame_oe && !frame_n_out) begin
                addr_cyc = cyc;
                addr_ad  = ad_out;
                addr_cbe = cbe_out;
            end else if (addr_cyc > 0 && frise < 0 && frame_n_out) begin
                frise = cyc;
            end
            if (!busy) begin
                fin = 1'b1;
                idle_cyc = cyc;
                chk_int("oe_off_in_idle", int'({frame_oe, irdy_oe, ad_oe, cbe_oe}), 0);
            end

            // arbiter and other bus masters
            gnt_n      = (cyc >= v.gdly) ? 1'b0 : 1'b1;
            frame_n_in = (cyc <= v.bbusy) ? 1'b0 : 1'b1;
            irdy_n_in  = frame_n_in;

            // target
            if (irdy_oe && !irdy_n_out) begin
                devsel_n = !v.dev;
                stop_n   = (tidx == v.sword) ? 1'b0 : 1'b1;
                ad_in    = rbase + 32'(tidx);
                if (tidx == v.wword && wleft > 0) begin
                    trdy_n = 1'b1;
                    wleft--;
                end else begin
                    trdy_n = v.dev ? 1'b0 : 1'b1;
                end
                if (!devsel_n && !trdy_n) tidx++;
            end else if (irdy_oe) begin
                devsel_n = !v.dev; trdy_n = 1'b1; stop_n = 1'b1;
            end else begin
                devsel_n = 1'b1; trdy_n = 1'b1; stop_n = 1'b1;
            end
            prev_ad = ad_out;
        end

        chk_int("words", words, v.e_words);
        chk_int("done_pulses", ndone, v.e_done ? 1 : 0);
        chk_int("abort_pulses", nabort, v.e_done ? 0 : 1);
        chk_int("addr_phase_cycle", addr_cyc, v.e_addr);
        chk_int("req_low_cycles", nreq, v.e_addr - 1);
        chk_int("frame_rise_cycle", frise, v.e_frise);
        chk_int("busy_low_cycle", idle_cyc, v.e_idle);
        chk32("addr_phase_ad", addr_ad, a);
        chk32("addr_phase_cbe", {28'd0, addr_cbe}, {28'd0, c});
        chk_int("scoreboard_left", sb_q.size(), 0);
        sb_q.delete();
        if (v.poke) begin
            @(negedge clk);
            chk_int("start_ignored_busy", int'({busy, req_n}), 1);
        end
        $display("txn %0d %s cnt=%0d words=%0d done=%0d abort=%0d addr@%0d frise@%0d idle@%0d",
                 vi, v.rd ? "RD" : "WR", v.cnt, words, ndone, nabort, addr_cyc, frise, idle_cyc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; start = 1'b0; cmd = 4'h0; addr = 32'h0; count = 3'd0; wdata = 32'h0;
        gnt_n = 1'b1; frame_n_in = 1'b1; irdy_n_in = 1'b1; trdy_n = 1'b1;
        devsel_n = 1'b1; stop_n = 1'b1; ad_in = 32'h0;

        //           rd   cnt  gd bb dev ww wl sw poke  ew done ad fr idle
        vecs[0] = '{1'b0, 3'd1, 0, 0, 1'b1, -1, 0, -1, 1'b0, 1, 1'b1, 2, 3, 5};
        vecs[1] = '{1'b1, 3'd4, 0, 0, 1'b1,  1, 2, -1, 1'b0, 4, 1'b1, 2, 8, 10};
        vecs[2] = '{1'b0, 3'd2, 0, 3, 1'b1, -1, 0, -1, 1'b0, 2, 1'b1, 5, 8, 10};
        vecs[3] = '{1'b0, 3'd2, 0, 0, 1'b0, -1, 0, -1, 1'b0, 0, 1'b0, 2, 8, 10};
        vecs[4] = '{1'b0, 3'd4, 0, 0, 1'b1, -1, 0,  1, 1'b0, 2, 1'b0, 2, 6, 8};
        vecs[5] = '{1'b1, 3'd0, 0, 0, 1'b1, -1, 0, -1, 1'b0, 1, 1'b1, 2, 3, 5};
        vecs[6] = '{1'b1, 3'd2, 2, 0, 1'b1, -1, 0, -1, 1'b0, 2, 1'b1, 3, 5, 7};
        vecs[7] = '{1'b1, 3'd3, 0, 0, 1'b0, -1, 0, -1, 1'b0, 0, 1'b0, 2, 8, 10};
        vecs[8] = '{1'b0, 3'd3, 1, 0, 1'b1,  0, 1, -1, 1'b1, 3, 1'b1, 2, 8, 10};
        vecs[9] = '{1'b1, 3'd4, 0, 0, 1'b1, -1, 0,  0, 1'b0, 1, 1'b0, 2, 4, 6};

        #12;
        chk_reset("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) run_txn(i, vecs[i]);

        // reset in the middle of a read burst, after one word has been captured
        cmd = 4'b0110; addr = 32'h1234_5678; count = 3'd4; start = 1'b1;
        gnt_n = 1'b0; frame_n_in = 1'b1; irdy_n_in = 1'b1; ad_in = 32'h77;
        devsel_n = 1'b1; trdy_n = 1'b1; stop_n = 1'b1;
        got = 1'b0;
        for (int cyc = 1; cyc <= 20 && !got; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (rdata_valid) got = 1'b1;
            else if (irdy_oe && !irdy_n_out) begin
                devsel_n = 1'b0;
                trdy_n   = 1'b0;
            end
        end
        trdy_n = 1'b1;
        chk32("rdata_before_reset", rdata, 32'h77);
        chk_int("busy_before_reset", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("mid_burst_reset");
        $display("txn reset mid-burst busy=%0d frame_oe=%0d rdata=%08h", busy, frame_oe, rdata);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(10, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
